ram_arbiter: RTL and testbench

Single-port access controller for the 256-byte system RAM. It shares the RAM between three requesters: the CPU bus, the button-capture path, and the LED display scanner. It issues exactly one RAM access per cycle under fixed priority and keeps an 8-row display line buffer, so the LED matrix no longer needs a second RAM read port. It sits between the CPU/control unit and the RAM; the top level builds the tristate data bus from `ram_wdata`/`ram_we`.

---
 rtl/ram_arbiter.sv | 133 +++++++++++++
 tb/tb_ram_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Fixed-priority (CPU > BTN > SCAN) single-port RAM access controller with an 8-row display
// line buffer. Define RAM_ARB_BTN_EN to build the button-capture path and its BTN access.
module ram_arbiter #(
   parameter logic [7:0]  DISP_BASE = 8'hF8,
   parameter logic [15:0] SCAN_DIV  = 16'd1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cpu_req,
   input  logic       cpu_we,
   input  logic [7:0] cpu_addr,
   input  logic [7:0] cpu_wdata,
   output logic [7:0] cpu_rdata,
   output logic       cpu_ack,
   input  logic       btn_strobe,
   input  logic [7:0] btn_value,
   output logic       btn_pending,
   output logic [7:0] ram_addr,
   output logic       ram_we,
   output logic       ram_oe,
   output logic [7:0] ram_wdata,
   input  logic [7:0] ram_rdata,
   input  logic [2:0] disp_sel,
   output logic [7:0] disp_row,
   output logic       disp_frame
);

   typedef enum logic [1:0] {IDLE, CPU, BTN, SCAN} state_t;

   state_t      state;
   logic [15:0] div;
   logic        scan_due;
   logic        scan_tc;
   logic [2:0]  row_idx;
   logic [7:0]  disp_buf [8];
   logic        cpu_elig;
   logic        btn_elig;
   logic        scan_elig;
   logic [7:0]  btn_data;

`ifdef RAM_ARB_BTN_EN
   logic       btn_strobe_d;
   logic       btn_rise;
   logic [7:0] btn_hold;

   // A fresh edge is eligible in the cycle it is sampled and carries its value straight through.
   assign btn_rise = btn_strobe & ~btn_strobe_d;
   assign btn_data = btn_rise ? btn_value : btn_hold;
   assign btn_elig = btn_rise | (btn_pending & (state != BTN));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         btn_strobe_d <= 1'b0;
         btn_hold     <= 8'h00;
         btn_pending  <= 1'b0;
      end else begin
         btn_strobe_d <= btn_strobe;
         if (btn_rise) begin
            btn_hold    <= btn_value;
            btn_pending <= 1'b1;
         end else if (state == BTN) begin
            btn_pending <= 1'b0;
         end
      end
   end
`else
   logic unused_btn;

   assign unused_btn  = ^{btn_strobe, btn_value};
   assign btn_data    = 8'h00;
   assign btn_elig    = 1'b0;
   assign btn_pending = 1'b0;
`endif

   // Each requester is masked at the edge that ends its own access, so a held request is not repeated.
   assign cpu_elig  = cpu_req & (state != CPU);
   assign scan_elig = scan_due & (state != SCAN);
   assign scan_tc   = (div == SCAN_DIV - 16'd1);
   assign disp_row  = disp_buf[disp_sel];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         ram_addr   <= 8'h00;
         ram_we     <= 1'b0;
         ram_oe     <= 1'b0;
         ram_wdata  <= 8'h00;
         cpu_ack    <= 1'b0;
         cpu_rdata  <= 8'h00;
         scan_due   <= 1'b0;
         div        <= 16'd0;
         row_idx    <= 3'd0;
         disp_frame <= 1'b0;
         for (int i = 0; i < 8; i++) disp_buf[i] <= 8'h00;
      end else begin
         cpu_ack    <= (state == CPU);
         disp_frame <= (state == SCAN) && (row_idx == 3'd7);
         if (state == CPU && ram_oe) cpu_rdata <= ram_rdata;
         if (state == SCAN) begin
            disp_buf[row_idx] <= ram_rdata;
            row_idx           <= row_idx + 3'd1;
         end

         div <= scan_tc ? 16'd0 : div + 16'd1;
         if (scan_tc)
            scan_due <= 1'b1;
         else if (state == SCAN)
            scan_due <= 1'b0;

         // Issue the access for the next cycle; address holds when idle.
         state  <= IDLE;
         ram_we <= 1'b0;
         ram_oe <= 1'b0;
         if (cpu_elig) begin
            state    <= CPU;
            ram_addr <= cpu_addr;
            ram_we   <= cpu_we;
            ram_oe   <= ~cpu_we;
            if (cpu_we) ram_wdata <= cpu_wdata;
         end else if (btn_elig) begin
            state     <= BTN;
            ram_addr  <= 8'h00;
            ram_we    <= 1'b1;
            ram_wdata <= btn_data;
         end else if (scan_elig) begin
            state    <= SCAN;
            ram_addr <= DISP_BASE + {5'd0, row_idx};
            ram_oe   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: a RAM model plus a negedge monitor that pops expected
// acks and RAM writes queued by the directed stimulus.
module tb_ram_arbiter;

   logic       clk;
   logic       reset;
   logic       cpu_req;
   logic       cpu_we;
   logic [7:0] cpu_addr;
   logic [7:0] cpu_wdata;
   logic [7:0] cpu_rdata;
   logic       cpu_ack;
   logic       btn_strobe;
   logic [7:0] btn_value;
   logic       btn_pending;
   logic [7:0] ram_addr;
   logic       ram_we;
   logic       ram_oe;
   logic [7:0] ram_wdata;
   logic [7:0] ram_rdata;
   logic [2:0] disp_sel;
   logic [7:0] disp_row;
   logic       disp_frame;

   logic [7:0]  mem [256];
   logic [8:0]  exp_ack[$];     // {is_read, rdata}
   logic [15:0] exp_cpu_wr[$];  // {addr, data}
   logic [15:0] exp_btn[$];     // {addr, data}
   int          checks;
   int          failures;
   int          frames;
   int          frames0;

   ram_arbiter #(.DISP_BASE(8'hF8), .SCAN_DIV(16'd4)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .btn_strobe(btn_strobe), .btn_value(btn_value), .btn_pending(btn_pending),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_oe(ram_oe), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata),
      .disp_sel(disp_sel), .disp_row(disp_row), .disp_frame(disp_frame)
   );

   assign ram_rdata = mem[ram_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cpu_access(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                             input logic [7:0] exp_rd);
      int lat;
      if (we) exp_cpu_wr.push_back({addr, wdata});
      exp_ack.push_back({~we, exp_rd});
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!cpu_ack && lat < 20);
      cpu_req = 1'b0;
      chk("cpu_latency", lat, 2);
   endtask

   // Four held back-to-back CPU writes with button edges placed at fixed cycles.
   task automatic cpu_burst(input int mode);
      int n;
      int cyc;
      for (int i = 0; i < 4; i++) begin
         exp_cpu_wr.push_back({8'(8'h40 + i), 8'(8'h50 + i)});
         exp_ack.push_back(9'h000);
      end
      if (mode == 1) exp_btn.push_back({8'h00, 8'hA5});
      else begin
         exp_btn.push_back({8'h00, 8'h01});
         exp_btn.push_back({8'h00, 8'h02});
      end
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h40; cpu_wdata = 8'h50;
      n = 0;
      cyc = 0;
      while (n < 4 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (cpu_ack) begin
            n++;
            cpu_addr  = 8'(8'h40 + n);
            cpu_wdata = 8'(8'h50 + n);
         end
         if (mode == 1) begin
            case (cyc)
               2: begin btn_value = 8'hA5; btn_strobe = 1'b1; end
               3: chk("btn_set", btn_pending, 1);
               4: chk("btn_slot", {ram_we, ram_addr, ram_wdata}, {1'b1, 8'h00, 8'hA5});
               5: chk("btn_clear", btn_pending, 0);
               default: ;
            endcase
         end else begin
            case (cyc)
               2: begin btn_value = 8'h01; btn_strobe = 1'b1; end
               3: btn_strobe = 1'b0;
               4: begin
                  chk("btn_slot1", {ram_we, ram_addr, ram_wdata}, {1'b1, 8'h00, 8'h01});
                  btn_value  = 8'h02;
                  btn_strobe = 1'b1;
               end
               5: chk("btn_set_wins", btn_pending, 1);
               6: chk("btn_slot2", {ram_we, ram_addr, ram_wdata}, {1'b1, 8'h00, 8'h02});
               7: chk("btn_clear2", btn_pending, 0);
               default: ;
            endcase
         end
      end
      cpu_req    = 1'b0;
      btn_strobe = 1'b0;
      if (n < 4) chk("burst_timeout", n, 4);
   endtask

   initial begin
      logic [8:0]  ea;
      logic [15:0] ew;
      checks = 0; failures = 0; frames = 0;
      reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
      btn_strobe = 1'b0; btn_value = 8'h00; disp_sel = 3'd0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      for (int i = 0; i < 8; i++) mem[8'hF8 + i] = 8'(i);
      mem[0] = 8'h99;

      fork
         forever begin
            @(posedge clk);
            if (ram_we) mem[ram_addr] <= ram_wdata;
         end
         forever begin
            @(negedge clk);
            if (cpu_ack) begin
               if (exp_ack.size() == 0) chk("unexpected_ack", 1, 0);
               else begin
                  ea = exp_ack.pop_front();
                  if (ea[8]) chk("cpu_rdata", cpu_rdata, ea[7:0]);
               end
            end
            if (ram_we) begin
               if (ram_addr == 8'h00) begin
                  if (exp_btn.size() == 0) chk("unexpected_addr0_wr", {ram_addr, ram_wdata}, 0);
                  else begin
                     ew = exp_btn.pop_front();
                     chk("addr0_wr", {ram_addr, ram_wdata}, ew);
                  end
               end else begin
                  if (exp_cpu_wr.size() == 0) chk("unexpected_wr", {ram_addr, ram_wdata}, 0);
                  else begin
                     ew = exp_cpu_wr.pop_front();
                     chk("cpu_wr", {ram_addr, ram_wdata}, ew);
                  end
               end
            end
            if (disp_frame) frames++;
         end
      join_none

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_oe", ram_oe, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_wdata", ram_wdata, 0);
      chk("rst_cpu_ack", cpu_ack, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_btn_pending", btn_pending, 0);
      chk("rst_disp_frame", disp_frame, 0);
      chk("rst_disp_row", disp_row, 0);

      // Scan: rows load at edges 6+4r, frames at 34+32k; 262 idle edges hold exactly 8 frames
      @(negedge clk);
      reset   = 1'b1;
      frames0 = frames;
      repeat (262) @(posedge clk);
      #1;
      chk("frame_count", frames - frames0, 8);
      for (int s = 0; s < 8; s++) begin
         disp_sel = 3'(s);
         #1;
         chk("disp_row", disp_row, s);
      end

      // CPU write then read back
      cpu_access(1'b1, 8'h10, 8'h3C, 8'h00);
      repeat (2) @(posedge clk);
      cpu_access(1'b0, 8'h10, 8'h00, 8'h3C);
      repeat (5) @(posedge clk);
      #1;
      chk("cpu_rdata_held", cpu_rdata, 8'h3C);
      cpu_access(1'b0, 8'hF9, 8'h00, 8'h01);
      repeat (3) @(posedge clk);

`ifdef RAM_ARB_BTN_EN
      cpu_burst(1);
      repeat (6) @(posedge clk);
      cpu_burst(2);
      repeat (6) @(posedge clk);
      #1;
      chk("addr0_final", mem[0], 8'h02);
`else
      @(negedge clk);
      btn_value  = 8'h5A;
      btn_strobe = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         chk("btn_pending_off", btn_pending, 0);
         if (c == 1) btn_strobe = 1'b0;
      end
      repeat (4) @(posedge clk);
      #1;
      chk("addr0_kept", mem[0], 8'h99);
`endif

      // Reset in the middle of a CPU write access
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wdata = 8'h77;
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      cpu_req = 1'b0;
      chk("mid_ram_we", ram_we, 0);
      chk("mid_ram_oe", ram_oe, 0);
      chk("mid_ram_addr", ram_addr, 0);
      chk("mid_ram_wdata", ram_wdata, 0);
      chk("mid_cpu_ack", cpu_ack, 0);
      chk("mid_cpu_rdata", cpu_rdata, 0);
      chk("mid_btn_pending", btn_pending, 0);
      chk("mid_disp_frame", disp_frame, 0);
      for (int s = 0; s < 8; s++) begin
         disp_sel = 3'(s);
         #1;
         chk("mid_disp_row", disp_row, 0);
      end
      repeat (3) @(posedge clk);
      #1;
      chk("mid_no_ack", cpu_ack, 0);
      chk("mid_wr_dropped", mem[8'h20], 8'h00);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(posedge clk);

      // Recovery after reset
      cpu_access(1'b0, 8'h10, 8'h00, 8'h3C);
      repeat (4) @(posedge clk);
      #1;
      chk("ack_queue_empty", exp_ack.size(), 0);
      chk("wr_queue_empty", exp_cpu_wr.size(), 0);
      chk("btn_queue_empty", exp_btn.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
